// File: rtl/order_uart_tx.sv
// order_uart_tx: turns buy/sell rising edges into 5-byte UART 8N1 order packets.
// Orders are captured with their price word, queued in a small FIFO and sent
// back-to-back as SYNC, side/stock, price high, price low, XOR checksum.
module order_uart_tx #(
   parameter int         CLK_HZ     = 100_000_000,
   parameter int         BAUD       = 115200,
   parameter int         FIFO_DEPTH = 4,        // power of 2, at least 2
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,                     // synchronous, active-low
   input  logic        enable,
   input  logic        buy_signal,
   input  logic        sell_signal,
   input  logic [15:0] price_word,
   output logic        tx,
   output logic        busy,
   output logic        fifo_full,
   output logic [7:0]  drop_cnt,
   output logic [7:0]  sent_cnt
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int BAUD_W       = $clog2(CLKS_PER_BIT);
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int CNT_W        = $clog2(FIFO_DEPTH + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   // queue entry: {buy, sell, stock_id[1:0], price[13:0]}
   logic [17:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              buy_d_q, sell_d_q;
   logic [7:0]        drop_cnt_q, sent_cnt_q;

   logic [1:0]        state_q, state_d;
   logic [17:0]       pkt_q, pkt_d;
   logic [2:0]        byte_idx_q, byte_idx_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic              pkt_done;

   logic buy_re, sell_re, want_push, conflict, pop, full, push_ok, drop;
   logic [7:0] b1, b2, b3, cur_byte;

   assign buy_re    = buy_signal & ~buy_d_q;
   assign sell_re   = sell_signal & ~sell_d_q;
   assign want_push = enable & (buy_re ^ sell_re);
   assign conflict  = enable & buy_re & sell_re;
   assign full      = (count_q == CNT_FULL);
   assign pop       = (state_q == S_IDLE) && (count_q != '0);
   // a pop in the same cycle frees the slot, so a full queue still accepts
   assign push_ok   = want_push & (~full | pop);
   assign drop      = conflict | (want_push & ~push_ok);

   // occupancy follows push/pop; simultaneous push and pop leaves it unchanged
   always_comb begin
      count_d = count_q;
      if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
   end

   // queue storage, written without reset so it maps onto plain RAM
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= {buy_re, sell_re, price_word};
   end

   // edge-detect history, queue pointers and drop counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         buy_d_q    <= 1'b0;
         sell_d_q   <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= 8'h00;
      end else begin
         buy_d_q  <= buy_signal;
         sell_d_q <= sell_signal;
         count_q  <= count_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'h01;
      end
   end

   // packet bytes derived from the frozen packet register
   assign b1 = {pkt_q[17], pkt_q[16], 4'b0000, pkt_q[15:14]};
   assign b2 = {2'b00, pkt_q[13:8]};
   assign b3 = pkt_q[7:0];

   // select the byte currently on the line
   always_comb begin
      case (byte_idx_q)
         3'd0:    cur_byte = SYNC_BYTE;
         3'd1:    cur_byte = b1;
         3'd2:    cur_byte = b2;
         3'd3:    cur_byte = b3;
         default: cur_byte = b1 ^ b2 ^ b3;
      endcase
   end

   // framing FSM: start bit, 8 data bits LSB first, stop bit, five bytes per packet
   always_comb begin
      state_d    = state_q;
      pkt_d      = pkt_q;
      byte_idx_d = byte_idx_q;
      bit_idx_d  = bit_idx_q;
      baud_d     = baud_q;
      pkt_done   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               pkt_d      = mem_q[rd_ptr_q];
               byte_idx_d = 3'd0;
               baud_d     = '0;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d    = '0;
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         S_DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) state_d = S_STOP;
               else                   bit_idx_d = bit_idx_q + 3'd1;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (byte_idx_q == 3'd4) begin
                  pkt_done = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  byte_idx_d = byte_idx_q + 3'd1;
                  state_d    = S_START;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
      endcase
   end

   // FSM registers; reset abandons any packet in flight
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         pkt_q      <= '0;
         byte_idx_q <= 3'd0;
         bit_idx_q  <= 3'd0;
         baud_q     <= '0;
         sent_cnt_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         pkt_q      <= pkt_d;
         byte_idx_q <= byte_idx_d;
         bit_idx_q  <= bit_idx_d;
         baud_q     <= baud_d;
         if (pkt_done) sent_cnt_q <= sent_cnt_q + 8'h01;
      end
   end

   // line level decoded straight from the FSM so tx drops in the first START cycle
   always_comb begin
      case (state_q)
         S_START: tx = 1'b0;
         S_DATA:  tx = cur_byte[bit_idx_q];
         default: tx = 1'b1;
      endcase
   end

   assign busy      = (state_q != S_IDLE) || (count_q != '0);
   assign fifo_full = full;
   assign drop_cnt  = drop_cnt_q;
   assign sent_cnt  = sent_cnt_q;

endmodule
